// File: rtl/icache_responder.sv
// Direct-mapped, read-only instruction cache with combinational hit path and a
// single-outstanding line-refill engine toward the backing memory bus.
module icache_responder #(
    parameter int unsigned LINES          = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] instructionAddress,
    output logic        instructionDataValid,
    output logic [31:0] instructionData,
    input  logic        invalidate,
    output logic        memRequestValid,
    input  logic        memRequestReady,
    output logic [31:0] memRequestAddress,
    input  logic        memResponseValid,
    input  logic [31:0] memResponseData
);

    localparam int unsigned OFF_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned IDX_W   = $clog2(LINES);
    localparam int unsigned IDX_LSB = 2 + OFF_W;
    localparam int unsigned TAG_LSB = IDX_LSB + IDX_W;
    localparam int unsigned TAG_W   = 32 - TAG_LSB;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    typedef enum logic [1:0] {
        IDLE,
        REQUEST,
        REFILL
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      data_q [LINES][WORDS_PER_LINE];
    logic [TAG_W-1:0] tag_q [LINES];
    logic [LINES-1:0] valid_q;

    logic [31:0]      line_addr_q, line_addr_d;
    logic [OFF_W-1:0] beat_q, beat_d;
    logic             kill_q, kill_d;
    logic             req_valid_q, req_valid_d;

    logic             miss_start;
    logic             beat_write;
    logic             line_done;

    logic [OFF_W-1:0] lookup_off;
    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] fill_idx;
    logic [TAG_W-1:0] fill_tag;
    logic             hit;
    logic             unused_addr_bits;

    // Lookup path: answered in the same cycle from the flop arrays.
    assign lookup_off = instructionAddress[2 +: OFF_W];
    assign lookup_idx = instructionAddress[IDX_LSB +: IDX_W];
    assign lookup_tag = instructionAddress[TAG_LSB +: TAG_W];
    assign unused_addr_bits = ^instructionAddress[1:0];

    assign hit = valid_q[lookup_idx] && (tag_q[lookup_idx] == lookup_tag);

    assign instructionDataValid = hit;
    assign instructionData      = hit ? data_q[lookup_idx][lookup_off] : 32'h0;

    assign fill_idx = line_addr_q[IDX_LSB +: IDX_W];
    assign fill_tag = line_addr_q[TAG_LSB +: TAG_W];

    assign memRequestValid   = req_valid_q;
    assign memRequestAddress = line_addr_q;

    // Refill controller next-state and strobes.
    always_comb begin
        state_d     = state_q;
        line_addr_d = line_addr_q;
        beat_d      = beat_q;
        kill_d      = kill_q;
        req_valid_d = req_valid_q;
        miss_start  = 1'b0;
        beat_write  = 1'b0;
        line_done   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // An invalidate in the same cycle wins; the miss is seen again next cycle.
                if (!hit && !invalidate) begin
                    miss_start  = 1'b1;
                    line_addr_d = {instructionAddress[31:IDX_LSB], {IDX_LSB{1'b0}}};
                    req_valid_d = 1'b1;
                    state_d     = REQUEST;
                end
            end
            REQUEST: begin
                kill_d = kill_q | invalidate;
                if (memRequestReady) begin
                    req_valid_d = 1'b0;
                    beat_d      = '0;
                    state_d     = REFILL;
                end
            end
            REFILL: begin
                kill_d = kill_q | invalidate;
                if (memResponseValid) begin
                    beat_write = 1'b1;
                    beat_d     = beat_q + OFF_W'(1);
                    if (beat_q == LAST_BEAT) begin
                        line_done = 1'b1;
                        kill_d    = 1'b0;
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control state and valid bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            beat_q      <= '0;
            kill_q      <= 1'b0;
            req_valid_q <= 1'b0;
            line_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            kill_q      <= kill_d;
            req_valid_q <= req_valid_d;
            line_addr_q <= line_addr_d;
            if (invalidate) begin
                valid_q <= '0;
            end else if (miss_start) begin
                valid_q[lookup_idx] <= 1'b0;
            end else if (line_done && !kill_q) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Data and tag arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clock) begin
        if (!reset && beat_write) begin
            data_q[fill_idx][beat_q] <= memResponseData;
        end
        if (!reset && line_done) begin
            tag_q[fill_idx] <= fill_tag;
        end
    end

endmodule
